// File: rtl/lsu_mem_arbiter_if.sv
// Bundle of LSU-lane request/response and data-memory signals shared by the arbiter.
// The slave modport is the arbiter's view; master is the lanes-plus-memory side.
interface lsu_mem_arbiter_if #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
);
    logic [NUM_LANES-1:0]        req_valid;
    logic [NUM_LANES-1:0]        req_is_load;
    logic [NUM_LANES*ADDR_W-1:0] req_addr;
    logic [NUM_LANES*DATA_W-1:0] req_wdata;
    logic [NUM_LANES-1:0]        req_ready;
    logic [NUM_LANES-1:0]        resp_valid;
    logic [DATA_W-1:0]           resp_rdata;
    logic                        mem_stall;
    logic                        mem_rd_en;
    logic                        mem_wr_en;
    logic [ADDR_W-1:0]           mem_addr;
    logic [DATA_W-1:0]           mem_wdata;
    logic [DATA_W-1:0]           mem_rdata;

    modport slave (
        input  req_valid, req_is_load, req_addr, req_wdata, mem_stall, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_is_load, req_addr, req_wdata, mem_stall, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_rd_en, mem_wr_en, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among NUM_LANES LSU slots,
// with a single outstanding 1-cycle load tracked for response routing.
module lsu_mem_arbiter #(
    parameter int unsigned NUM_LANES = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    lsu_mem_arbiter_if.slave    bus
);
    localparam int unsigned LW = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    logic [LW-1:0] rr_ptr_q, rr_ptr_d;
    logic          pend_valid_q, pend_valid_d;
    logic [LW-1:0] pend_lane_q, pend_lane_d;

    logic          gnt_found;
    logic [LW-1:0] gnt_idx;
    logic          grant_en;
    logic          gnt_is_load;

    // First valid lane at or after rr_ptr, wrapping modulo NUM_LANES.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr_q) + k) % NUM_LANES;
            if (!gnt_found && bus.req_valid[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = LW'(idx);
            end
        end
    end

    assign grant_en    = rst_n && !bus.mem_stall && gnt_found;
    assign gnt_is_load = bus.req_is_load[gnt_idx];

    always_comb begin
        bus.req_ready = '0;
        bus.mem_rd_en = 1'b0;
        bus.mem_wr_en = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (grant_en) begin
            bus.req_ready[gnt_idx] = 1'b1;
            bus.mem_rd_en          = gnt_is_load;
            bus.mem_wr_en          = !gnt_is_load;
            bus.mem_addr           = bus.req_addr[32'(gnt_idx) * ADDR_W +: ADDR_W];
            if (!gnt_is_load) begin
                bus.mem_wdata = bus.req_wdata[32'(gnt_idx) * DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        bus.resp_valid = '0;
        bus.resp_rdata = '0;
        if (rst_n && pend_valid_q) begin
            bus.resp_valid[pend_lane_q] = 1'b1;
            bus.resp_rdata              = bus.mem_rdata;
        end
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        pend_valid_d = grant_en && gnt_is_load;
        pend_lane_d  = pend_lane_q;
        if (grant_en) begin
            rr_ptr_d = (gnt_idx == LW'(NUM_LANES - 1)) ? '0 : gnt_idx + 1'b1;
            if (gnt_is_load) begin
                pend_lane_d = gnt_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q     <= '0;
            pend_valid_q <= 1'b0;
            pend_lane_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            pend_valid_q <= pend_valid_d;
            pend_lane_q  <= pend_lane_d;
        end
    end

    a_ready_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready));
    a_resp_onehot0:  assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.resp_valid));
    a_rd_wr_excl:    assert property (@(posedge clk) disable iff (!rst_n) !(bus.mem_rd_en && bus.mem_wr_en));
endmodule

// File: tb/tb_lsu_mem_arbiter.sv
// Directed bench for lsu_mem_arbiter: a per-cycle scoreboard built from the arbitration
// rules (nearest valid lane after the pointer, 1-cycle load return) plus literal checks.
module tb_lsu_mem_arbiter;
    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    lsu_mem_arbiter_if #(.NUM_LANES(N), .ADDR_W(AW), .DATA_W(DW)) bus();

    lsu_mem_arbiter #(.NUM_LANES(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], ~a[15:0]};
    endfunction

    // Memory: read data appears the cycle after the read strobe; garbage otherwise.
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= memf(bus.mem_addr);
        else               bus.mem_rdata <= 32'hBAD0_BAD0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state: pointer and the single outstanding load.
    int          m_ptr  = 0;
    bit          m_pend = 0;
    int          m_lane = 0;
    logic [31:0] m_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_ptr = 0; m_pend = 0; m_lane = 0;
                chk("rst_ready", bus.req_ready, 0);
                chk("rst_resp", bus.resp_valid, 0);
                chk("rst_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 0);
                chk("rst_addr", bus.mem_addr, 0);
                chk("rst_wdata", bus.mem_wdata, 0);
            end else begin
                int best, bestd;
                bit grant, ld;
                logic [N-1:0] e_ready, e_resp;
                best = -1; bestd = N;
                for (int i = 0; i < N; i++) begin
                    if (bus.req_valid[i] && ((i - m_ptr + N) % N) < bestd) begin
                        bestd = (i - m_ptr + N) % N;
                        best  = i;
                    end
                end
                grant   = (best >= 0) && !bus.mem_stall;
                ld      = grant && bus.req_is_load[best];
                e_ready = grant ? N'(1 << best) : '0;
                e_resp  = m_pend ? N'(1 << m_lane) : '0;
                chk("sb_ready", bus.req_ready, e_ready);
                chk("sb_rd_en", bus.mem_rd_en, ld);
                chk("sb_wr_en", bus.mem_wr_en, grant && !ld);
                if (grant) begin
                    chk("sb_addr", bus.mem_addr, bus.req_addr[best*AW +: AW]);
                    chk("sb_wdata", bus.mem_wdata, ld ? 32'h0 : bus.req_wdata[best*DW +: DW]);
                end
                if (bus.req_valid == 0) begin
                    chk("sb_idle_addr", bus.mem_addr, 0);
                    chk("sb_idle_wdata", bus.mem_wdata, 0);
                end
                chk("sb_resp_valid", bus.resp_valid, e_resp);
                chk("sb_resp_rdata", bus.resp_rdata, m_pend ? memf(m_addr) : 32'h0);
                if (grant) m_ptr = (best + 1) % N;
                m_pend = ld;
                if (ld) begin
                    m_lane = best;
                    m_addr = bus.req_addr[best*AW +: AW];
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic set_lane(input int i, input bit v, input bit ld,
                            input logic [31:0] a, input logic [31:0] d);
        bus.req_valid[i]          = v;
        bus.req_is_load[i]        = ld;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    logic [N-1:0] seq [4];
    logic [N-1:0] acc;

    initial begin
        rst_n = 1'b0;
        bus.mem_stall = 1'b0;
        set_lane(0, 1, 1, 32'h10, 32'h0);
        set_lane(1, 1, 1, 32'h20, 32'h0);

        // Reset with all lanes valid, then first grant goes to lane 0.
        @(negedge clk);
        chk("t1_reset_ready", bus.req_ready, 2'b00);
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_grant", bus.req_ready, 2'b01);
        cyc(); bus.req_valid = '0;
        @(negedge clk);
        chk("t1_resp_lane0", bus.resp_valid, 2'b01);

        // Single load from lane 1.
        cyc(); set_lane(1, 1, 1, 32'h100, 32'h0);
        @(negedge clk);
        chk("t2_ready", bus.req_ready, 2'b10);
        chk("t2_rd_en", bus.mem_rd_en, 1'b1);
        chk("t2_addr", bus.mem_addr, 32'h100);
        cyc(); bus.req_valid = '0;
        @(negedge clk);
        chk("t2_resp_valid", bus.resp_valid, 2'b10);
        chk("t2_resp_rdata", bus.resp_rdata, 32'hDEADBEEF);

        // Contention: both lanes load for 4 cycles.
        cyc();
        set_lane(0, 1, 1, 32'h200, 32'h0);
        set_lane(1, 1, 1, 32'h300, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seq[k] = bus.req_ready;
            if (k > 0) chk("t3_resp_follows", bus.resp_valid, seq[k-1]);
            cyc();
        end
        bus.req_valid = '0;
        @(negedge clk);
        chk("t3_resp_last", bus.resp_valid, seq[3]);
        chk("t3_grant0", seq[0], 2'b01);
        chk("t3_grant1", seq[1], 2'b10);
        chk("t3_grant2", seq[2], 2'b01);
        chk("t3_grant3", seq[3], 2'b10);

        // Store from lane 0.
        cyc(); set_lane(0, 1, 0, 32'h4, 32'h55);
        @(negedge clk);
        chk("t4_wr_en", bus.mem_wr_en, 1'b1);
        chk("t4_rd_en", bus.mem_rd_en, 1'b0);
        chk("t4_addr", bus.mem_addr, 32'h4);
        chk("t4_wdata", bus.mem_wdata, 32'h55);
        cyc(); bus.req_valid = '0;
        @(negedge clk);
        chk("t4_no_resp", bus.resp_valid, 2'b00);

        // Stall for 3 cycles with lane 0 valid.
        cyc(); set_lane(0, 1, 1, 32'h40, 32'h0); bus.mem_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t5_stall_ready", bus.req_ready, 2'b00);
            chk("t5_stall_strobes", {bus.mem_rd_en, bus.mem_wr_en}, 2'b00);
            cyc();
            if (k == 2) bus.mem_stall = 1'b0;
        end
        @(negedge clk);
        chk("t5_unstall_grant", bus.req_ready, 2'b01);
        // Stall while the response is pending: response still arrives.
        cyc(); bus.req_valid = '0; set_lane(1, 1, 1, 32'h44, 32'h0); bus.mem_stall = 1'b1;
        @(negedge clk);
        chk("t5_resp_in_stall", bus.resp_valid, 2'b01);
        chk("t5_rdata_in_stall", bus.resp_rdata, memf(32'h40));
        chk("t5_ready_in_stall", bus.req_ready, 2'b00);
        cyc(); bus.mem_stall = 1'b0; bus.req_valid = '0;

        // Only lane 1 valid: granted every cycle.
        cyc(); set_lane(1, 1, 1, 32'h500, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("b_single_lane", bus.req_ready, 2'b10);
            cyc();
        end
        bus.req_valid = '0;

        // Reset the cycle after a load grant.
        cyc(); set_lane(0, 1, 1, 32'h600, 32'h0);
        @(negedge clk);
        chk("t6_grant", bus.req_ready, 2'b01);
        cyc(); rst_n = 1'b0; bus.req_valid = 2'b11;
        @(negedge clk);
        chk("t6_resp_in_reset", bus.resp_valid, 2'b00);
        cyc(); rst_n = 1'b1;
        @(negedge clk);
        chk("t6_resp_after", bus.resp_valid, 2'b00);
        chk("t6_ptr_reset", bus.req_ready, 2'b01);
        cyc(); bus.req_valid = '0;

        // Mixed traffic; payload only changes once accepted or idle.
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            acc = bus.req_ready;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (acc[i] || !bus.req_valid[i]) begin
                    set_lane(i, ((c + i) % 3) != 0, ((c >> i) & 1) == 1,
                             32'h1000 + 32'(c * 16 + i * 4), 32'(c * 7 + i));
                end
            end
            bus.mem_stall = (c % 7 == 5);
        end
        bus.req_valid = '0; bus.mem_stall = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
